// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over NUM_CH valid/ready channels feeding one registered output word.
// Optional burst locking lets a channel keep the grant for up to MAX_BURST consecutive transfers.
module rr_mux_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 10,
    parameter int SEL_W     = $clog2(NUM_CH),
    parameter int MAX_BURST = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST   = BURST_W'(MAX_BURST - 1);
    localparam logic [SEL_W-1:0]   LAST_CH_INIT = SEL_W'(NUM_CH - 1);

    logic [DATA_W-1:0]  chData [NUM_CH];

    logic [DATA_W-1:0]  outData_q,  outData_d;
    logic [SEL_W-1:0]   outSel_q,   outSel_d;
    logic               outValid_q, outValid_d;
    logic [SEL_W-1:0]   lastCh_q,   lastCh_d;
    logic [BURST_W-1:0] burstCnt_q, burstCnt_d;

    logic               slotFree;
    logic               load;
    logic               stay;
    logic [SEL_W-1:0]   scanCh;
    logic [SEL_W-1:0]   cand;

    for (genvar k = 0; k < NUM_CH; k++) begin : gUnpack
        assign chData[k] = in_data[k*DATA_W +: DATA_W];
    end

    assign slotFree = !outValid_q || out_ready;
    assign load     = slotFree && (|in_valid) && reset;
    assign stay     = in_valid[lastCh_q] && (burstCnt_q < BURST_LAST);
    assign cand     = stay ? lastCh_q : scanCh;

    // Scanning from the farthest offset down lets the nearest valid channel after lastCh win;
    // offset NUM_CH wraps back onto lastCh itself, so it is only chosen when alone.
    always_comb begin
        int idx;
        idx    = 0;
        scanCh = lastCh_q;
        for (int off = NUM_CH; off >= 1; off--) begin
            idx = (int'(lastCh_q) + off) % NUM_CH;
            if (in_valid[idx]) begin
                scanCh = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            in_ready[k] = load && (cand == SEL_W'(k));
        end
    end

    always_comb begin
        outData_d  = outData_q;
        outSel_d   = outSel_q;
        outValid_d = outValid_q;
        lastCh_d   = lastCh_q;
        burstCnt_d = burstCnt_q;
        if (load) begin
            outData_d  = chData[cand];
            outSel_d   = cand;
            outValid_d = 1'b1;
            lastCh_d   = cand;
            burstCnt_d = stay ? burstCnt_q + 1'b1 : '0;
        end else if (slotFree) begin
            outValid_d = 1'b0;
        end
    end

    // Reset leaves the burst exhausted on the last channel so arbitration restarts at channel 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            outData_q  <= '0;
            outSel_q   <= '0;
            outValid_q <= 1'b0;
            lastCh_q   <= LAST_CH_INIT;
            burstCnt_q <= BURST_LAST;
        end else begin
            outData_q  <= outData_d;
            outSel_q   <= outSel_d;
            outValid_q <= outValid_d;
            lastCh_q   <= lastCh_d;
            burstCnt_q <= burstCnt_d;
        end
    end

    assign out_data  = outData_q;
    assign out_sel   = outSel_q;
    assign out_valid = outValid_q;

endmodule
